// File: rtl/manchester_tx_arbiter.sv
// manchester_tx_arbiter
//   Round-robin arbiter that merges NUM_SRC AXI-Stream byte sources onto the
//   single stream feeding the preamble/encoder TX path. A grant is held for a
//   whole frame (until the tlast handshake), after which IFG_CYCLES idle cycles
//   are enforced before the next arbitration.
//
// Ports
//   aclk, areset      : clock, synchronous active-high reset
//   s_axis_tdata      : packed source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid/tlast/tready : per-source handshake, bit i = source i
//   m_axis_tdata/tvalid/tready/tlast : shared output stream
//   grant_id          : current or most recently granted source
//   busy              : high while a frame is in flight or the gap is running
module manchester_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int IFG_CYCLES = 12
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [GW-1:0]   winner;
  logic            found;
  logic            frame_done;

  // Round-robin search: candidate k steps above last_grant wins if it is the
  // first requester found. Constant indices keep the mux free of wide selects.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && s_axis_tvalid[i] &&
            (i == (int'(last_grant_q) + k) % NUM_SRC)) begin
          found  = 1'b1;
          winner = GW'(i);
        end
      end
    end
  end

  // Zero-latency pass-through of the granted source while in XFER.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == GW'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (frame_done) begin
          last_grant_d = grant_q;
          if (IFG_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = 8'(IFG_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // Counter value 1 marks the final gap cycle, giving exactly IFG_CYCLES.
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_manchester_tx_arbiter.sv
module tb_manchester_tx_arbiter;

  localparam int DW      = 8;
  localparam int NS      = 4;
  localparam int IFG     = 12;
  // Beat-to-beat distance across a frame boundary: IFG gap cycles plus the
  // single IDLE arbitration cycle, then the next beat.
  localparam int SPACING = IFG + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [1:0]        grant_id;
  logic              busy;

  logic [NS*DW-1:0]  c_tdata;
  logic [NS-1:0]     c_tvalid, c_tlast, c_tready;
  logic [DW-1:0]     c_m_tdata;
  logic              c_m_tvalid, c_m_tready, c_m_tlast;
  logic [1:0]        c_grant_id;
  logic              c_busy;

  manchester_tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IFG_CYCLES(IFG)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .grant_id(grant_id), .busy(busy)
  );

  manchester_tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IFG_CYCLES(0)) dut0 (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(c_tdata), .s_axis_tvalid(c_tvalid), .s_axis_tlast(c_tlast),
    .s_axis_tready(c_tready),
    .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
    .m_axis_tlast(c_m_tlast), .grant_id(c_grant_id), .busy(c_busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  beat_t src_q [NS][$];
  exp_t  sb[$];
  int    cyc_q[$];
  int    cyc = 0;
  int    beats_seen = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int src, input logic [DW-1:0] data, input logic last);
    beat_t b;
    exp_t  e;
    b.data = data;
    b.last = last;
    e.src  = 2'(src);
    e.data = data;
    e.last = last;
    src_q[src].push_back(b);
    sb.push_back(e);
  endtask

  task automatic send(input int src, input logic [DW-1:0] first, input int len);
    for (int j = 0; j < len; j++)
      push_beat(src, first + DW'(j), (j == len - 1));
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int n = 0; n < max_cycles && sb.size() != 0; n++) step();
    check(tag, sb.size(), 0);
    repeat (16) step();
  endtask

  task automatic check_spacing(input string tag, input int n, input int brk, input int dflt);
    check({tag, "_count"}, cyc_q.size(), n);
    for (int j = 1; j < cyc_q.size(); j++)
      check(tag, cyc_q[j] - cyc_q[j-1], (j == brk) ? SPACING : dflt);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source models: present the head of each queue, pop on handshake.
  initial begin
    logic [NS-1:0] hs;
    beat_t         b;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          b = src_q[i][0];
          s_tvalid[i]         = 1'b1;
          s_tlast[i]          = b.last;
          s_tdata[i*DW +: DW] = b.data;
        end else begin
          s_tvalid[i]         = 1'b0;
          s_tlast[i]          = 1'b0;
          s_tdata[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Output monitor: every accepted beat must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        check("beat_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_data", m_tdata, e.data);
          check("beat_last", m_tlast, e.last);
          check("beat_grant", grant_id, e.src);
        end
        cyc_q.push_back(cyc);
        beats_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation stalled");
  end

  initial begin
    int   base;
    logic ok;
    int   idx;
    int   hk[4];

    areset     = 1'b1;
    m_tready   = 1'b0;
    c_tdata    = '0;
    c_tvalid   = '0;
    c_tlast    = '0;
    c_m_tready = 1'b0;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    step();
    areset   = 1'b0;
    m_tready = 1'b1;

    // Sources 0 and 2 each with a 3-beat frame: 0 first, gap, then 2
    cyc_q.delete();
    send(0, 8'h10, 3);
    send(2, 8'h20, 3);
    drain("t1_drain", 200);
    check_spacing("t1_spacing", 6, 3, 1);
    check("t1_grant_hold", grant_id, 2);
    check("t1_busy_idle", busy, 0);

    // All four sources continuously valid with one-beat frames
    areset = 1'b1;
    step();
    areset = 1'b0;
    cyc_q.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NS; i++)
        send(i, 8'(i * 16 + f), 1);
    drain("t2_drain", 400);
    check_spacing("t2_spacing", 8, -1, SPACING);

    // Backpressure toggling during a 4-beat frame from source 1
    m_tready = 1'b0;
    cyc_q.delete();
    push_beat(1, 8'hAA, 1'b0);
    push_beat(1, 8'hBB, 1'b0);
    push_beat(1, 8'hCC, 1'b0);
    push_beat(1, 8'hDD, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = busy;
      if (!ok) step();
    end
    check("t3_granted", 32'(ok), 1);
    check("t3_ready_stall", s_tready, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      m_tready = (k % 2 == 0);
      @(negedge clk);
      check("t3_ready_mirror", s_tready, m_tready ? 4'b0010 : 4'b0000);
    end
    m_tready = 1'b1;
    drain("t3_drain", 100);
    check_spacing("t3_spacing", 4, -1, 2);

    // Source 0 requests while source 3 is mid-frame
    cyc_q.delete();
    base = beats_seen;
    send(3, 8'h60, 5);
    for (int n = 0; n < 60 && beats_seen < base + 2; n++) step();
    check("t4_two_beats", beats_seen - base, 2);
    send(0, 8'h70, 2);
    drain("t4_drain", 200);
    check_spacing("t4_spacing", 7, 5, 1);

    // Reset pulse during beat 2 of a frame from source 2
    base = beats_seen;
    send(2, 8'h80, 4);
    for (int n = 0; n < 60 && beats_seen < base + 1; n++) step();
    check("t5_one_beat", beats_seen - base, 1);
    areset   = 1'b1;
    m_tready = 1'b0;
    src_q[2].delete();
    sb.delete();
    step();
    areset = 1'b0;
    @(negedge clk);
    check("t5_m_tvalid", m_tvalid, 0);
    check("t5_m_tlast", m_tlast, 0);
    check("t5_s_tready", s_tready, 0);
    check("t5_busy", busy, 0);
    check("t5_grant_id", grant_id, 0);
    cyc_q.delete();
    m_tready = 1'b1;
    send(0, 8'h91, 1);
    send(2, 8'h90, 1);
    drain("t5_drain", 100);
    check_spacing("t5_spacing", 2, -1, SPACING);

    // IFG_CYCLES=0: back-to-back 2-beat frames from source 1
    c_m_tready = 1'b1;
    c_tvalid   = 4'b0010;
    idx        = 0;
    for (int k = 0; k < 12 && idx < 4; k++) begin
      c_tdata = 32'(8'h50 + idx) << 8;
      c_tlast = (idx % 2 == 1) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c_m_tvalid && c_m_tready) begin
        check("t6_data", c_m_tdata, 8'h50 + idx);
        check("t6_last", c_m_tlast, (idx % 2 == 1));
        check("t6_ready", c_tready, 4'b0010);
        check("t6_grant", c_grant_id, 1);
        hk[idx] = k;
        idx++;
      end
      step();
    end
    c_tvalid = '0;
    c_tlast  = '0;
    check("t6_beats", idx, 4);
    if (idx == 4) begin
      check("t6_in_frame", hk[1] - hk[0], 1);
      check("t6_idle_gap", hk[2] - hk[1], 2);
      check("t6_in_frame2", hk[3] - hk[2], 1);
    end
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
